// File: rtl/spi_target_if.sv
// SPI pins plus the RX/TX word handshake of spi_target, bundled for port connection.
interface spi_target_if #(
  parameter int unsigned DATA_W = 8
);
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              spi_miso;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic              cs_active;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, tx_data, tx_valid,
    output spi_miso, rx_data, rx_valid, tx_ready, tx_underrun, cs_active
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, tx_data, tx_valid,
    input  spi_miso, rx_data, rx_valid, tx_ready, tx_underrun, cs_active
  );
endinterface

// File: rtl/spi_target.sv
// Mode-0 SPI target oversampled by the system clock, with a one-entry TX holding buffer.
module spi_target #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = {DATA_W{1'b1}}
) (
  input logic         CLK,
  input logic         RST_N,
  spi_target_if.slave bus
);
  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sclk_q, cs_n_q;
  logic [1:0]        mosi_q;
  logic [1:0]        settle_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-2:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q, rx_data_q, buf_q, rx_next;
  logic              buf_full_q, rx_valid_q, underrun_q;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              start, reload, buf_wr, last_bit, in_shift;

  // Index 0/1 form the synchronizer, index 2 is the edge-detect copy.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_n_q[1] & cs_n_q[2];
  assign cs_rise   = cs_n_q[1] & ~cs_n_q[2];
  assign in_shift  = (state_q == StShift);
  assign last_bit  = (bit_cnt_q == CntW'(DATA_W - 1));
  assign rx_next   = {rx_shift_q, mosi_q[1]};
  assign buf_wr    = bus.tx_valid & ~buf_full_q;
  assign reload    = start | (in_shift & sclk_fall & (bit_cnt_q == '0) & ~cs_rise);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sclk_q   <= '0;
      cs_n_q   <= '1;
      mosi_q   <= '0;
      settle_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      cs_n_q <= {cs_n_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
      // Suppress the false cs edge seen while the synchronizer refills after reset.
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cs_fall && (settle_q == 2'd3)) begin
          state_d = StShift;
          start   = 1'b1;
        end
      end
      StShift: begin
        if (cs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (buf_wr) begin
        buf_q      <= bus.tx_data;
        buf_full_q <= 1'b1;
      end
      // A reload samples the pre-write buffer state, so a same-cycle write is retained.
      if (reload) begin
        if (buf_full_q) begin
          tx_shift_q <= buf_q;
          buf_full_q <= 1'b0;
        end else begin
          tx_shift_q <= IDLE_BYTE;
          underrun_q <= 1'b1;
        end
      end else if (in_shift && sclk_fall && (bit_cnt_q != '0)) begin
        tx_shift_q <= tx_shift_q << 1;
      end
      if (start || (in_shift && cs_rise)) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
      end else if (in_shift && sclk_rise) begin
        rx_shift_q <= rx_next[DATA_W-2:0];
        if (last_bit) begin
          bit_cnt_q  <= '0;
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
      end
    end
  end

  assign bus.spi_miso    = in_shift ? tx_shift_q[DATA_W-1] : 1'b1;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = ~buf_full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.cs_active   = ~cs_n_q[1];
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: SCLK at CLK/8, frames built bit by bit from the initiator side.
`timescale 1ns/1ps
module tb_spi_target;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_target_if #(.DATA_W(8)) bus_if ();

  spi_target #(.DATA_W(8), .IDLE_BYTE(8'hFF)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus_if)
  );

  int n_chk = 0;
  int n_pass = 0;
  int und_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (bus_if.rx_valid) rx_log.push_back(bus_if.rx_data);
    if (bus_if.tx_underrun) und_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_miso"}, 32'(bus_if.spi_miso), 1);
    chk({p, "_rx_data"}, 32'(bus_if.rx_data), 0);
    chk({p, "_rx_valid"}, 32'(bus_if.rx_valid), 0);
    chk({p, "_tx_ready"}, 32'(bus_if.tx_ready), 1);
    chk({p, "_underrun"}, 32'(bus_if.tx_underrun), 0);
    chk({p, "_cs_active"}, 32'(bus_if.cs_active), 0);
  endtask

  task automatic push(input logic [7:0] d);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = d;
    clk_n(1);
    bus_if.tx_valid = 1'b0;
  endtask

  task automatic start_frame();
    bus_if.spi_cs_n = 1'b0;
    clk_n(8);
  endtask

  task automatic end_frame();
    bus_if.spi_sclk = 1'b0;
    clk_n(4);
    bus_if.spi_cs_n = 1'b1;
    clk_n(8);
  endtask

  // Shifts nbits MSB-first; leaves SCLK high after the last bit. Optionally refills
  // the TX buffer during the fourth bit.
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic refill,
                      input logic [7:0] rdata, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus_if.spi_sclk = 1'b0;
      bus_if.spi_mosi = mo[i];
      clk_n(4);
      if (i == 4) begin
        bus_if.tx_valid = refill;
        bus_if.tx_data  = rdata;
        clk_n(1);
        bus_if.tx_valid = 1'b0;
      end
      mi[i] = bus_if.spi_miso;
      bus_if.spi_sclk = 1'b1;
      clk_n(4);
    end
  endtask

  logic [7:0] m0, m1, m2;
  int und0, rx0;

  initial begin
    bus_if.spi_sclk = 1'b0;
    bus_if.spi_mosi = 1'b0;
    bus_if.spi_cs_n = 1'b1;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = '0;
    clk_n(3);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    clk_n(4);

    // Buffered A5 out, 3C in
    push(8'hA5);
    chk("t1_ready_full", 32'(bus_if.tx_ready), 0);
    und0 = und_cnt;
    rx0  = rx_log.size();
    start_frame();
    chk("t1_ready_start", 32'(bus_if.tx_ready), 1);
    chk("t1_cs_active", 32'(bus_if.cs_active), 1);
    xfer(8'h3C, 8, 1'b0, 8'h00, m0);
    chk("t1_underrun", 32'(und_cnt - und0), 0);
    end_frame();
    chk("t1_miso", 32'(m0), 32'hA5);
    chk("t1_rx_count", 32'(rx_log.size() - rx0), 1);
    chk("t1_rx_word", 32'(rx_log[rx0]), 32'h3C);
    chk("t1_rx_data", 32'(bus_if.rx_data), 32'h3C);

    // Empty buffer: idle byte plus underrun
    und0 = und_cnt;
    rx0  = rx_log.size();
    start_frame();
    xfer(8'h5A, 8, 1'b0, 8'h00, m0);
    chk("t2_underrun", 32'(und_cnt - und0), 1);
    end_frame();
    chk("t2_miso", 32'(m0), 32'hFF);
    chk("t2_rx_count", 32'(rx_log.size() - rx0), 1);
    chk("t2_rx_word", 32'(rx_log[rx0]), 32'h5A);

    // Back-to-back three words with refill
    push(8'h10);
    und0 = und_cnt;
    rx0  = rx_log.size();
    start_frame();
    xfer(8'h01, 8, 1'b1, 8'h20, m0);
    xfer(8'h02, 8, 1'b1, 8'h30, m1);
    xfer(8'h03, 8, 1'b0, 8'h00, m2);
    chk("t3_underrun", 32'(und_cnt - und0), 0);
    end_frame();
    chk("t3_miso0", 32'(m0), 32'h10);
    chk("t3_miso1", 32'(m1), 32'h20);
    chk("t3_miso2", 32'(m2), 32'h30);
    chk("t3_rx_count", 32'(rx_log.size() - rx0), 3);
    chk("t3_rx0", 32'(rx_log[rx0]), 32'h01);
    chk("t3_rx1", 32'(rx_log[rx0+1]), 32'h02);
    chk("t3_rx2", 32'(rx_log[rx0+2]), 32'h03);

    // Aborted partial word, then a clean frame
    rx0 = rx_log.size();
    start_frame();
    xfer(8'hF0, 5, 1'b0, 8'h00, m0);
    end_frame();
    chk("t4_partial_no_rx", 32'(rx_log.size() - rx0), 0);
    start_frame();
    xfer(8'h81, 8, 1'b0, 8'h00, m0);
    end_frame();
    chk("t4_rx_count", 32'(rx_log.size() - rx0), 1);
    chk("t4_rx_word", 32'(rx_log[rx0]), 32'h81);
    chk("t4_rx_data", 32'(bus_if.rx_data), 32'h81);

    // Offer while full must not overwrite
    push(8'h11);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = 8'h22;
    clk_n(3);
    chk("t5_ready_full", 32'(bus_if.tx_ready), 0);
    bus_if.tx_valid = 1'b0;
    clk_n(1);
    und0 = und_cnt;
    start_frame();
    xfer(8'hC3, 8, 1'b0, 8'h00, m0);
    xfer(8'h3C, 8, 1'b0, 8'h00, m1);
    chk("t5_underrun", 32'(und_cnt - und0), 1);
    end_frame();
    chk("t5_miso0", 32'(m0), 32'h11);
    chk("t5_miso1", 32'(m1), 32'hFF);

    // Reset mid-frame after 4 bits
    rx0 = rx_log.size();
    start_frame();
    xfer(8'hAA, 4, 1'b0, 8'h00, m0);
    bus_if.spi_sclk = 1'b0;
    clk_n(4);
    rst_n = 1'b0;
    clk_n(1);
    chk_reset_outs("t6");
    rst_n = 1'b1;
    clk_n(8);
    bus_if.spi_cs_n = 1'b1;
    clk_n(8);
    chk("t6_no_rx", 32'(rx_log.size() - rx0), 0);
    push(8'h96);
    start_frame();
    xfer(8'hC3, 8, 1'b0, 8'h00, m0);
    end_frame();
    chk("t6_miso", 32'(m0), 32'h96);
    chk("t6_rx_count", 32'(rx_log.size() - rx0), 1);
    chk("t6_rx_word", 32'(rx_log[rx0]), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
